sa_feeder: RTL and testbench

Upstream feeder for the weight-stationary systolic array (2x2 default). Each job has two phases:
- Weight load: accepts ROWS weight row-vectors over a valid/ready handshake and drives them onto the array's weight inputs with weight_en asserted.
- Activation stream: accepts activation column-vectors over valid/ready and emits them skewed, with row r delayed r cycles, onto the array's left-edge activation inputs. It then drains and pulses done.

---
 rtl/sa_pkg.sv | 20 ++
 rtl/sa_skew_line.sv | 43 ++++
 rtl/sa_feeder.sv | 174 +++++++++++++++++
 tb/tb_sa_feeder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder: default element width,
// controller state encoding and the drain-length helper.
package sa_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Cycles needed to flush the activation skew and let the last product
  // leave the array.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// One activation lane of the skew network: a DEPTH-stage register chain for
// data plus a matching valid bit. Shifts every cycle; the array has no
// backpressure so there is no stall input.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_vld,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld
);

  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;

  // Shift data and valid one stage per cycle; bubbles travel like data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= ZERO_D;
      end
      r_vld <= {DEPTH{1'b0}};
    end else begin
      r_data[0] <= i_data;
      r_vld[0]  <= i_vld;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
    end
  end

  assign o_data = r_data[DEPTH-1];
  assign o_vld  = r_vld[DEPTH-1];

endmodule

// File: rtl/sa_feeder.sv
// Upstream feeder for a weight-stationary systolic array. A job loads ROWS
// weight rows, then streams activation vectors through a per-row skew so
// that row r lags row 0 by r cycles, drains the skew and pulses done.
module sa_feeder
  import sa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = 2,
  parameter int COLS   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [COLS*DATA_W-1:0] i_w_data,
  input  logic                   i_w_valid,
  output logic                   o_w_ready,
  input  logic [ROWS*DATA_W-1:0] i_a_data,
  input  logic                   i_a_valid,
  input  logic                   i_a_last,
  output logic                   o_a_ready,
  output logic [COLS*DATA_W-1:0] o_weight_out,
  output logic                   o_weight_en,
  output logic [ROWS*DATA_W-1:0] o_act_out,
  output logic [ROWS-1:0]        o_act_vld,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int DRAIN_N = drain_len(ROWS, COLS);
  localparam int WCNT_W  = $clog2(ROWS + 1);
  localparam int DCNT_W  = $clog2(DRAIN_N + 1);

  localparam logic [WCNT_W-1:0]      W_LAST = WCNT_W'(ROWS - 1);
  localparam logic [DCNT_W-1:0]      D_LAST = DCNT_W'(DRAIN_N - 1);
  localparam logic [WCNT_W-1:0]      W_ZERO = {WCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0]      D_ZERO = {DCNT_W{1'b0}};
  localparam logic [WCNT_W-1:0]      W_ONE  = WCNT_W'(1);
  localparam logic [DCNT_W-1:0]      D_ONE  = DCNT_W'(1);
  localparam logic [COLS*DATA_W-1:0] ZERO_W = {(COLS*DATA_W){1'b0}};
  localparam logic [ROWS*DATA_W-1:0] ZERO_A = {(ROWS*DATA_W){1'b0}};

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WCNT_W-1:0]       r_w_cnt;
  logic [WCNT_W-1:0]       w_w_cnt_nxt;
  logic [DCNT_W-1:0]       r_d_cnt;
  logic [DCNT_W-1:0]       w_d_cnt_nxt;
  logic                    w_done_nxt;

  logic                    r_w_ready;
  logic                    r_a_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_weight_en;
  logic [COLS*DATA_W-1:0]  r_weight_out;

  logic                    w_w_acc;
  logic                    w_a_acc;
  logic [ROWS*DATA_W-1:0]  w_act_in;

  // Handshakes use the registered ready flags, so an accept can only happen
  // in the phase that advertises readiness.
  assign w_w_acc  = i_w_valid & r_w_ready;
  assign w_a_acc  = i_a_valid & r_a_ready;
  assign w_act_in = w_a_acc ? i_a_data : ZERO_A;

  // Next-state and counter logic for the job controller.
  always_comb begin
    w_state_nxt = r_state;
    w_w_cnt_nxt = r_w_cnt;
    w_d_cnt_nxt = r_d_cnt;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = LOAD_W;
          w_w_cnt_nxt = W_ZERO;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD_W: begin
        if (w_w_acc) begin
          if (r_w_cnt == W_LAST) begin
            w_state_nxt = STREAM;
            w_w_cnt_nxt = W_ZERO;
          end else begin
            w_w_cnt_nxt = r_w_cnt + W_ONE;
          end
        end else begin
          w_w_cnt_nxt = r_w_cnt;
        end
      end
      STREAM: begin
        if (w_a_acc && i_a_last) begin
          w_state_nxt = DRAIN;
          w_d_cnt_nxt = D_ZERO;
        end else begin
          w_state_nxt = STREAM;
        end
      end
      DRAIN: begin
        if (r_d_cnt == D_LAST) begin
          w_state_nxt = IDLE;
          w_d_cnt_nxt = D_ZERO;
        end else begin
          w_d_cnt_nxt = r_d_cnt + D_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_w_cnt_nxt = W_ZERO;
        w_d_cnt_nxt = D_ZERO;
      end
    endcase
    // done is registered, so it is decided from where the FSM is heading.
    w_done_nxt = (w_state_nxt == DRAIN) && (w_d_cnt_nxt == D_LAST);
  end

  // State and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_w_cnt <= W_ZERO;
      r_d_cnt <= D_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_w_cnt <= w_w_cnt_nxt;
      r_d_cnt <= w_d_cnt_nxt;
    end
  end

  // Registered control outputs and the weight path; weights are visible for
  // exactly the one cycle after their accept and are zero otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_w_ready    <= 1'b0;
      r_a_ready    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_weight_en  <= 1'b0;
      r_weight_out <= ZERO_W;
    end else begin
      r_w_ready    <= (w_state_nxt == LOAD_W);
      r_a_ready    <= (w_state_nxt == STREAM);
      r_busy       <= (w_state_nxt != IDLE);
      r_done       <= w_done_nxt;
      r_weight_en  <= w_w_acc;
      r_weight_out <= w_w_acc ? i_w_data : ZERO_W;
    end
  end

  // Lane r gets r+1 stages so row r lags row 0 by r cycles.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    sa_skew_line #(
      .DEPTH  (r + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_data (w_act_in[r*DATA_W +: DATA_W]),
      .i_vld  (w_a_acc),
      .o_data (o_act_out[r*DATA_W +: DATA_W]),
      .o_vld  (o_act_vld[r])
    );
  end

  assign o_w_ready    = r_w_ready;
  assign o_a_ready    = r_a_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_weight_en  = r_weight_en;
  assign o_weight_out = r_weight_out;

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder (2x2, 16-bit): a hand-derived vector table for one
// full job and a restart, hand sequences for reset corner cases, and a long
// randomized run checked against a cycle-level behavioural model.
module tb_sa_feeder;

  localparam int DATA_W = 16;
  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int HMAX   = 8192;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_STREAM = 2;
  localparam int P_DRAIN  = 3;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [COLS*DATA_W-1:0] w_data;
  logic                   w_valid;
  logic                   w_ready;
  logic [ROWS*DATA_W-1:0] a_data;
  logic                   a_valid;
  logic                   a_last;
  logic                   a_ready;
  logic [COLS*DATA_W-1:0] weight_out;
  logic                   weight_en;
  logic [ROWS*DATA_W-1:0] act_out;
  logic [ROWS-1:0]        act_vld;
  logic                   busy;
  logic                   done;

  int n_tests = 0;
  int n_fail  = 0;

  sa_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_w_data     (w_data),
    .i_w_valid    (w_valid),
    .o_w_ready    (w_ready),
    .i_a_data     (a_data),
    .i_a_valid    (a_valid),
    .i_a_last     (a_last),
    .o_a_ready    (a_ready),
    .o_weight_out (weight_out),
    .o_weight_en  (weight_en),
    .o_act_out    (act_out),
    .o_act_vld    (act_vld),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  // Accepted activation history indexed by clock edge; row r shows the
  // vector accepted r edges before the most recent one.
  logic                   hist_vld [HMAX];
  logic [ROWS*DATA_W-1:0] hist_dat [HMAX];
  int                     e         = 0;
  int                     hist_base = 0;
  int                     m_phase   = P_IDLE;
  int                     m_wrows   = 0;
  int                     m_dleft   = 0;
  int                     m_jobs    = 0;
  logic                   m_wen     = 1'b0;
  logic [COLS*DATA_W-1:0] m_wout    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_wen     = 1'b0;
    m_wout    = '0;
    hist_base = e;
  endtask

  task automatic compare_model();
    logic [ROWS*DATA_W-1:0] exp_act;
    logic [ROWS-1:0]        exp_vld;
    exp_act = '0;
    exp_vld = '0;
    for (int r = 0; r < ROWS; r++) begin
      int idx;
      idx = e - 1 - r;
      if (idx >= hist_base && hist_vld[idx]) begin
        exp_act[r*DATA_W +: DATA_W] = hist_dat[idx][r*DATA_W +: DATA_W];
        exp_vld[r] = 1'b1;
      end
    end
    check("m_weight_en",  64'(weight_en),  64'(m_wen));
    check("m_weight_out", 64'(weight_out), 64'(m_wout));
    check("m_act_out",    64'(act_out),    64'(exp_act));
    check("m_act_vld",    64'(act_vld),    64'(exp_vld));
    check("m_w_ready",    64'(w_ready),    64'(m_phase == P_LOAD));
    check("m_a_ready",    64'(a_ready),    64'(m_phase == P_STREAM));
    check("m_busy",       64'(busy),       64'(m_phase != P_IDLE));
    check("m_done",       64'(done),       64'(m_phase == P_DRAIN && m_dleft == 1));
  endtask

  // One clock edge: decide accepts from the model phase and the driven
  // inputs, advance the model, then sample the DUT 1 time unit after the edge.
  task automatic tick();
    logic                   st, wa, aa, al;
    logic [COLS*DATA_W-1:0] wd;
    logic [ROWS*DATA_W-1:0] ad;
    st = !rst && (m_phase == P_IDLE) && start;
    wa = !rst && (m_phase == P_LOAD) && w_valid;
    aa = !rst && (m_phase == P_STREAM) && a_valid;
    al = a_last;
    wd = w_data;
    ad = a_data;
    @(posedge clk);
    #1;
    hist_vld[e] = aa;
    hist_dat[e] = aa ? ad : '0;
    e++;
    if (rst) begin
      model_reset();
    end else begin
      m_wen  = wa;
      m_wout = wa ? wd : '0;
      case (m_phase)
        P_IDLE:   if (st) begin m_phase = P_LOAD; m_wrows = 0; end
        P_LOAD:   if (wa) begin
                    m_wrows++;
                    if (m_wrows == ROWS) m_phase = P_STREAM;
                  end
        P_STREAM: if (aa && al) begin m_phase = P_DRAIN; m_dleft = ROWS + COLS - 1; end
        default:  begin
                    m_dleft--;
                    if (m_dleft == 0) begin m_phase = P_IDLE; m_jobs++; end
                  end
      endcase
    end
    compare_model();
  endtask

  task automatic idle_inputs();
    start = 1'b0; w_valid = 1'b0; w_data = '0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_weight_out"}, 64'(weight_out), 64'd0);
    check({name, "_weight_en"},  64'(weight_en),  64'd0);
    check({name, "_act_out"},    64'(act_out),    64'd0);
    check({name, "_act_vld"},    64'(act_vld),    64'd0);
    check({name, "_w_ready"},    64'(w_ready),    64'd0);
    check({name, "_a_ready"},    64'(a_ready),    64'd0);
    check({name, "_busy"},       64'(busy),       64'd0);
    check({name, "_done"},       64'(done),       64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        start;
    logic        w_valid;
    logic [31:0] w_data;
    logic        a_valid;
    logic [31:0] a_data;
    logic        a_last;
    logic        wen;
    logic [31:0] wout;
    logic [31:0] act;
    logic [1:0]  vld;
    logic        wrdy;
    logic        ardy;
    logic        bsy;
    logic        dn;
  } vec_t;

  function automatic vec_t mk(logic st, logic wv, logic [31:0] wd, logic av,
                              logic [31:0] ad, logic al, logic wen, logic [31:0] wout,
                              logic [31:0] act, logic [1:0] vld, logic wr, logic ar,
                              logic bz, logic dn);
    vec_t v;
    v.start = st; v.w_valid = wv; v.w_data = wd; v.a_valid = av; v.a_data = ad;
    v.a_last = al; v.wen = wen; v.wout = wout; v.act = act; v.vld = vld;
    v.wrdy = wr; v.ardy = ar; v.bsy = bz; v.dn = dn;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();

    // Fill the table: inputs before edge i, outputs expected just after it.
    tbl[0]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 32'h0008_0007, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0008_0007, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 32'h0006_0005, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0006_0005, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0002_0001, 1'b0, 1'b0, 32'h0, 32'h0000_0001, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0004_0003, 1'b1, 1'b0, 32'h0, 32'h0002_0003, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 32'h0000_1234, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0004_0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[7]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 32'h0002_0001, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0002_0001, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 32'h0004_0003, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0004_0003, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0009_0009, 1'b0, 1'b0, 32'h0, 32'h0000_0009, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0009_0000, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h000A_000A, 1'b1, 1'b0, 32'h0, 32'h0000_000A, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h000A_0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Power-on reset.
    tick();
    tick();
    check_zero("por");
    rst = 1'b0;
    tick();

    // Reset asserted mid-cycle while idle, then stray valids with no start.
    rst = 1'b1;
    #1;
    check_zero("idle_rst");
    model_reset();
    w_valid = 1'b1; w_data = 32'hDEAD_BEEF;
    a_valid = 1'b1; a_data = 32'hCAFE_F00D; a_last = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("idle_stray");
    end
    idle_inputs();
    tick();

    // Directed table: weight load, skew, drain/done, ignored start, bubble.
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; w_valid = tbl[i].w_valid; w_data = tbl[i].w_data;
      a_valid = tbl[i].a_valid; a_data = tbl[i].a_data; a_last = tbl[i].a_last;
      tick();
      check($sformatf("t%0d_weight_en", i),  64'(weight_en),  64'(tbl[i].wen));
      check($sformatf("t%0d_weight_out", i), 64'(weight_out), 64'(tbl[i].wout));
      check($sformatf("t%0d_act_out", i),    64'(act_out),    64'(tbl[i].act));
      check($sformatf("t%0d_act_vld", i),    64'(act_vld),    64'(tbl[i].vld));
      check($sformatf("t%0d_w_ready", i),    64'(w_ready),    64'(tbl[i].wrdy));
      check($sformatf("t%0d_a_ready", i),    64'(a_ready),    64'(tbl[i].ardy));
      check($sformatf("t%0d_busy", i),       64'(busy),       64'(tbl[i].bsy));
      check($sformatf("t%0d_done", i),       64'(done),       64'(tbl[i].dn));
    end
    idle_inputs();

    // Reset one cycle after the first activation accept: immediate clear.
    start = 1'b1; tick(); start = 1'b0;
    w_valid = 1'b1; w_data = 32'h0011_0022; tick();
    w_data = 32'h0033_0044; tick(); w_valid = 1'b0;
    a_valid = 1'b1; a_data = 32'h0055_0066; tick(); a_valid = 1'b0;
    tick();
    check("rs_act_vld_before", 64'(act_vld), 64'(2'b10));
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    model_reset();
    tick();
    check_zero("mid_rst_held");
    rst = 1'b0;
    tick();

    // One clean job after the abort; a_last on the first stream vector.
    start = 1'b1; tick(); start = 1'b0;
    w_valid = 1'b1; w_data = 32'h0101_0202; tick();
    w_data = 32'h0303_0404; tick(); w_valid = 1'b0;
    a_valid = 1'b1; a_data = 32'h0A0A_0B0B; a_last = 1'b1; tick();
    a_valid = 1'b0; a_last = 1'b0;
    for (int i = 0; i < 40 && m_phase != P_IDLE; i++) tick();
    check("post_rst_job_idle", 64'(m_phase == P_IDLE), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);

    // Randomized traffic: every input toggles freely, the model decides.
    for (int i = 0; i < 2000; i++) begin
      start   = ($urandom_range(0, 5) == 0);
      w_valid = ($urandom_range(0, 3) != 0);
      w_data  = $urandom;
      a_valid = ($urandom_range(0, 3) != 0);
      a_data  = $urandom;
      a_last  = ($urandom_range(0, 4) == 0);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 40 && m_phase != P_IDLE; i++) tick();
    check("random_jobs_completed", 64'(m_jobs >= 20), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
